// File: rtl/uart_frame_tx.sv
// Framed 8N1 UART transmitter fed by a payload FIFO.
// Frame on the line: HEADER, LEN, payload[0..LEN-1], CSUM = (LEN + sum(payload)) mod 256.
module uart_frame_tx #(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD_RATE  = 115_200,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] HEADER     = 8'hA5,
  localparam int        CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          send_req,
  output logic          fifo_full,
  output logic [CW-1:0] fifo_count,
  output logic          busy,
  output logic          frame_done,
  output logic          uart_tx_port
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_DATA, S_CSUM} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_byte, r_len, r_csum, r_remaining;
  logic [3:0]    r_bit_cnt;
  logic [BW-1:0] r_baud_cnt;
  logic          r_tx, r_done;

  logic          w_push, w_pop, w_accept, w_load, w_bit_end, w_byte_end, w_bit;
  logic [7:0]    w_byte_nxt, w_head;
  logic [2:0]    w_bit_idx;

  assign w_bit_end  = (r_baud_cnt == BAUD_LAST);
  assign w_byte_end = w_bit_end && (r_bit_cnt == 4'd9);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_bit_idx  = 3'(r_bit_cnt - 4'd1);
  assign w_push     = wr_en && ((r_count != COUNT_MAX) || w_pop);

  // busy stays up through the frame_done cycle so a new request lands after it
  assign busy         = (r_state != S_IDLE) || r_done;
  assign frame_done   = r_done;
  assign uart_tx_port = r_tx;
  assign fifo_count   = r_count;
  assign fifo_full    = (r_count == COUNT_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_byte_nxt  = r_byte;
    case (r_state)
      S_IDLE: if (send_req && !r_done && (r_count != '0)) begin
        w_accept    = 1'b1;
        w_load      = 1'b1;
        w_byte_nxt  = HEADER;
        w_state_nxt = S_HDR;
      end
      S_HDR: if (w_byte_end) begin
        w_load      = 1'b1;
        w_byte_nxt  = r_len;
        w_state_nxt = S_LEN;
      end
      S_LEN: if (w_byte_end) begin
        w_load      = 1'b1;
        w_pop       = 1'b1;
        w_byte_nxt  = w_head;
        w_state_nxt = S_DATA;
      end
      S_DATA: if (w_byte_end) begin
        w_load = 1'b1;
        if (r_remaining != 8'd0) begin
          w_pop      = 1'b1;
          w_byte_nxt = w_head;
        end else begin
          w_byte_nxt  = r_csum;
          w_state_nxt = S_CSUM;
        end
      end
      S_CSUM: if (w_byte_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    if (r_bit_cnt == 4'd0)      w_bit = 1'b0;
    else if (r_bit_cnt == 4'd9) w_bit = 1'b1;
    else                        w_bit = r_byte[w_bit_idx];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_byte      <= '0;
      r_len       <= '0;
      r_csum      <= '0;
      r_remaining <= '0;
      r_bit_cnt   <= '0;
      r_baud_cnt  <= '0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_CSUM) && w_byte_end;
      // line is registered one cycle behind the bit counters
      r_tx    <= (r_state == S_IDLE) ? 1'b1 : w_bit;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_remaining <= r_remaining - 8'd1;
        r_csum      <= r_csum + w_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_accept) begin
        r_len       <= 8'(r_count);
        r_remaining <= 8'(r_count);
        r_csum      <= 8'(r_count);
      end
      if (w_load) r_byte <= w_byte_nxt;
      if (r_state == S_IDLE) begin
        r_bit_cnt  <= '0;
        r_baud_cnt <= '0;
      end else if (w_bit_end) begin
        r_baud_cnt <= '0;
        r_bit_cnt  <= (r_bit_cnt == 4'd9) ? 4'd0 : r_bit_cnt + 4'd1;
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: mid-bit UART monitor plus a queue model of FIFO and framing rules.
module tb_uart_frame_tx;
  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 77_000;
  localparam int BD        = CLK_FREQ / BAUD_RATE;  // 12, truncated from 12.98
  localparam int DEPTH     = 16;
  localparam int CW        = $clog2(DEPTH + 1);

  typedef logic [7:0] bq_t[$];

  logic          sys_clk = 1'b0, sys_rst = 1'b1, wr_en = 1'b0, send_req = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          fifo_full, busy, frame_done, uart_tx_port;
  logic [CW-1:0] fifo_count;

  int   pass_cnt = 0, total_cnt = 0, cyc = 0, done_total = 0, stop_errs = 0;
  bq_t  model_q, rx_q;
  int   rx_start[$];

  uart_frame_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(DEPTH), .HEADER(8'hA5)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_data(wr_data), .send_req(send_req),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .busy(busy), .frame_done(frame_done),
    .uart_tx_port(uart_tx_port));

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(posedge sys_clk) if (frame_done === 1'b1) done_total++;

  // Line decoder: start found on the first low cycle, then each bit sampled mid-bit.
  initial begin : mon
    logic [7:0] b;
    int st;
    forever begin
      @(negedge sys_clk);
      if (uart_tx_port === 1'b0) begin
        st = cyc;
        repeat (BD / 2) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge sys_clk);
          b[i] = uart_tx_port;
        end
        repeat (BD) @(negedge sys_clk);
        if (uart_tx_port !== 1'b1) stop_errs++;
        rx_q.push_back(b);
        rx_start.push_back(st);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Model: LEN is the queued count at send time; checksum is plain modular arithmetic.
  function automatic bq_t take_frame();
    bq_t f;
    int n = model_q.size();
    int s = n;
    f.push_back(8'hA5);
    f.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      s += int'(model_q[0]);
      f.push_back(model_q.pop_front());
    end
    f.push_back(8'(s % 256));
    return f;
  endfunction

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    @(posedge sys_clk); #1;
    wr_en = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(b);
  endtask

  task automatic send(output int acc);
    rx_q.delete(); rx_start.delete();
    send_req = 1'b1; acc = cyc;
    @(posedge sys_clk); #1;
    send_req = 1'b0;
  endtask

  task automatic wait_done(input int nbytes, output int done_at);
    done_at = -1;
    for (int i = 0; i < nbytes * 10 * BD + 4 * BD; i++) begin
      @(negedge sys_clk);
      if (frame_done === 1'b1) begin
        done_at = cyc;
        break;
      end
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    total_cnt++; if (uart_tx_port !== 1'b1) $display("FAIL reset_line got %b want 1", uart_tx_port); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_done got %b want 0", frame_done); else pass_cnt++;
    total_cnt++; if (fifo_count !== '0) $display("FAIL reset_count got %0d want 0", fifo_count); else pass_cnt++;
    total_cnt++; if (fifo_full !== 1'b0) $display("FAIL reset_full got %b want 0", fifo_full); else pass_cnt++;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_basic();
    int acc, dn;
    logic [7:0] got;
    bq_t exp = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
    push(8'h01); push(8'h02); push(8'h03);
    void'(take_frame());
    send(acc);
    total_cnt++; if (busy !== 1'b1 || uart_tx_port !== 1'b1) $display("FAIL basic_first_cycle busy=%b line=%b want 1/1", busy, uart_tx_port); else pass_cnt++;
    wait_done(exp.size(), dn);
    total_cnt++; if (dn !== acc + 1 + 6 * 10 * BD) $display("FAIL basic_done_cycle got %0d want %0d", dn, acc + 1 + 60 * BD); else pass_cnt++;
    total_cnt++; if (rx_start.size() == 0 || rx_start[0] !== acc + 2) $display("FAIL basic_start_cycle got %0d want %0d", (rx_start.size() > 0) ? rx_start[0] : -1, acc + 2); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || uart_tx_port !== 1'b1 || fifo_count !== '0) $display("FAIL basic_after busy=%b line=%b count=%0d want 0/1/0", busy, uart_tx_port, fifo_count); else pass_cnt++;
    total_cnt++; if (rx_q.size() !== exp.size()) $display("FAIL basic_nbytes got %0d want %0d", rx_q.size(), exp.size()); else pass_cnt++;
    for (int i = 0; i < exp.size(); i++) begin
      got = 8'hxx; if (i < rx_q.size()) got = rx_q[i];
      total_cnt++; if (got !== exp[i]) $display("FAIL basic_byte%0d got %h want %h", i, got, exp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_ignored();
    int acc, dn, d0;
    logic [7:0] got;
    bq_t exp;
    d0 = done_total;
    send(acc);
    repeat (3 * BD) @(posedge sys_clk);
    #1;
    total_cnt++; if (rx_q.size() !== 0 || busy !== 1'b0) $display("FAIL empty_send bytes=%0d busy=%b want 0/0", rx_q.size(), busy); else pass_cnt++;
    total_cnt++; if (done_total !== d0) $display("FAIL empty_send_done got %0d pulses want 0", done_total - d0); else pass_cnt++;
    push(8'h5A); push(8'h3C);
    exp = take_frame();
    d0 = done_total;
    send(acc);
    push(8'h77);
    repeat (15 * BD) @(posedge sys_clk);
    #1;
    send_req = 1'b1; @(posedge sys_clk); #1; send_req = 1'b0;
    wait_done(exp.size(), dn);
    total_cnt++; if (dn !== acc + 1 + exp.size() * 10 * BD) $display("FAIL busy_send_done_cycle got %0d want %0d", dn, acc + 1 + exp.size() * 10 * BD); else pass_cnt++;
    for (int i = 0; i < exp.size(); i++) begin
      got = 8'hxx; if (i < rx_q.size()) got = rx_q[i];
      total_cnt++; if (got !== exp[i]) $display("FAIL busy_send_byte%0d got %h want %h", i, got, exp[i]); else pass_cnt++;
    end
    repeat (3 * BD) @(posedge sys_clk);
    #1;
    total_cnt++; if (done_total - d0 !== 1 || rx_q.size() !== exp.size()) $display("FAIL busy_send_extra pulses=%0d bytes=%0d want 1/%0d", done_total - d0, rx_q.size(), exp.size()); else pass_cnt++;
    total_cnt++; if (fifo_count !== CW'(model_q.size())) $display("FAIL busy_send_queued got %0d want %0d", fifo_count, model_q.size()); else pass_cnt++;
    exp = take_frame();
    send(acc);
    wait_done(exp.size(), dn);
    for (int i = 0; i < exp.size(); i++) begin
      got = 8'hxx; if (i < rx_q.size()) got = rx_q[i];
      total_cnt++; if (got !== exp[i]) $display("FAIL queued_frame_byte%0d got %h want %h", i, got, exp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_full();
    int acc, dn;
    logic [7:0] got;
    bq_t exp;
    for (int i = 0; i <= 16; i++) push(8'(i));
    total_cnt++; if (fifo_full !== 1'b1 || fifo_count !== CW'(16)) $display("FAIL full_flags full=%b count=%0d want 1/16", fifo_full, fifo_count); else pass_cnt++;
    exp.push_back(8'hA5); exp.push_back(8'h10);
    for (int i = 0; i < 16; i++) exp.push_back(8'(i));
    exp.push_back(8'h88);
    void'(take_frame());
    send(acc);
    wait_done(exp.size(), dn);
    total_cnt++; if (dn !== acc + 1 + exp.size() * 10 * BD) $display("FAIL full_done_cycle got %0d want %0d", dn, acc + 1 + exp.size() * 10 * BD); else pass_cnt++;
    total_cnt++; if (fifo_full !== 1'b0 || fifo_count !== '0) $display("FAIL full_after full=%b count=%0d want 0/0", fifo_full, fifo_count); else pass_cnt++;
    for (int i = 0; i < exp.size(); i++) begin
      got = 8'hxx; if (i < rx_q.size()) got = rx_q[i];
      total_cnt++; if (got !== exp[i]) $display("FAIL full_byte%0d got %h want %h", i, got, exp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    int acc, dn;
    logic [7:0] got;
    bq_t exp = '{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00};
    push(8'hFF); push(8'hFF);
    void'(take_frame());
    send(acc);
    wait_done(exp.size(), dn);
    total_cnt++; if (rx_q.size() !== exp.size()) $display("FAIL wrap_nbytes got %0d want %0d", rx_q.size(), exp.size()); else pass_cnt++;
    for (int i = 0; i < exp.size(); i++) begin
      got = 8'hxx; if (i < rx_q.size()) got = rx_q[i];
      total_cnt++; if (got !== exp[i]) $display("FAIL wrap_byte%0d got %h want %h", i, got, exp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_same_cycle();
    int acc, dn;
    logic [7:0] got;
    bq_t exp1 = '{8'hA5, 8'h01, 8'h11, 8'h12};
    bq_t exp2 = '{8'hA5, 8'h01, 8'hAA, 8'hAB};
    push(8'h11);
    void'(take_frame());
    rx_q.delete(); rx_start.delete();
    wr_en = 1'b1; wr_data = 8'hAA; send_req = 1'b1; acc = cyc;
    @(posedge sys_clk); #1;
    wr_en = 1'b0; send_req = 1'b0;
    model_q.push_back(8'hAA);
    wait_done(exp1.size(), dn);
    total_cnt++; if (dn !== acc + 1 + 4 * 10 * BD) $display("FAIL same_cycle_done got %0d want %0d", dn, acc + 1 + 40 * BD); else pass_cnt++;
    total_cnt++; if (fifo_count !== CW'(1)) $display("FAIL same_cycle_count got %0d want 1", fifo_count); else pass_cnt++;
    for (int i = 0; i < exp1.size(); i++) begin
      got = 8'hxx; if (i < rx_q.size()) got = rx_q[i];
      total_cnt++; if (got !== exp1[i]) $display("FAIL same_cycle_f1_byte%0d got %h want %h", i, got, exp1[i]); else pass_cnt++;
    end
    void'(take_frame());
    send(acc);
    wait_done(exp2.size(), dn);
    for (int i = 0; i < exp2.size(); i++) begin
      got = 8'hxx; if (i < rx_q.size()) got = rx_q[i];
      total_cnt++; if (got !== exp2[i]) $display("FAIL same_cycle_f2_byte%0d got %h want %h", i, got, exp2[i]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int acc, dn, lows, d0;
    logic [7:0] got;
    bq_t exp;
    for (int i = 0; i < 3; i++) push(8'($urandom_range(255, 0)));
    void'(take_frame());
    send(acc);
    for (int i = 0; i < 5 * 10 * BD && rx_q.size() < 3; i++) @(posedge sys_clk);
    #1;
    total_cnt++; if (rx_q.size() < 3) $display("FAIL mid_reset_reach got %0d bytes want 3", rx_q.size()); else pass_cnt++;
    repeat (4 * BD) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    model_q.delete();
    total_cnt++; if (uart_tx_port !== 1'b1 || busy !== 1'b0 || fifo_count !== '0) $display("FAIL mid_reset_state line=%b busy=%b count=%0d want 1/0/0", uart_tx_port, busy, fifo_count); else pass_cnt++;
    lows = 0; d0 = done_total;
    repeat (20 * BD) begin
      @(negedge sys_clk);
      if (uart_tx_port !== 1'b1) lows++;
    end
    @(posedge sys_clk); #1;
    total_cnt++; if (lows !== 0 || done_total !== d0) $display("FAIL mid_reset_quiet low_cycles=%0d pulses=%0d want 0/0", lows, done_total - d0); else pass_cnt++;
    push(8'($urandom_range(255, 0))); push(8'($urandom_range(255, 0)));
    exp = take_frame();
    send(acc);
    wait_done(exp.size(), dn);
    total_cnt++; if (dn !== acc + 1 + exp.size() * 10 * BD) $display("FAIL post_reset_done got %0d want %0d", dn, acc + 1 + exp.size() * 10 * BD); else pass_cnt++;
    for (int i = 0; i < exp.size(); i++) begin
      got = 8'hxx; if (i < rx_q.size()) got = rx_q[i];
      total_cnt++; if (got !== exp[i]) $display("FAIL post_reset_byte%0d got %h want %h", i, got, exp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int acc, dn, n;
    logic [7:0] got;
    bq_t exp;
    for (int it = 0; it < 5; it++) begin
      n = int'($urandom_range(20, 1));
      for (int k = 0; k < n; k++) push(8'($urandom_range(255, 0)));
      total_cnt++; if (fifo_count !== CW'(model_q.size()) || fifo_full !== (model_q.size() == DEPTH)) $display("FAIL rand%0d_fill count=%0d full=%b want %0d", it, fifo_count, fifo_full, model_q.size()); else pass_cnt++;
      exp = take_frame();
      send(acc);
      wait_done(exp.size(), dn);
      total_cnt++; if (dn !== acc + 1 + exp.size() * 10 * BD) $display("FAIL rand%0d_done got %0d want %0d", it, dn, acc + 1 + exp.size() * 10 * BD); else pass_cnt++;
      total_cnt++; if (rx_q.size() !== exp.size()) $display("FAIL rand%0d_nbytes got %0d want %0d", it, rx_q.size(), exp.size()); else pass_cnt++;
      for (int i = 0; i < exp.size(); i++) begin
        got = 8'hxx; if (i < rx_q.size()) got = rx_q[i];
        total_cnt++; if (got !== exp[i]) $display("FAIL rand%0d_byte%0d got %h want %h", it, i, got, exp[i]); else pass_cnt++;
      end
    end
    total_cnt++; if (stop_errs !== 0) $display("FAIL stop_bits got %0d bad stop bits want 0", stop_errs); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignored();
    test_full();
    test_wrap();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
